// File: rtl/serial_output.sv
// serial_output: 8-bit UART transmitter fed by a 32-bit stb/ack word stream (byte = input_in[7:0]).
// Define SERIAL_OUTPUT_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module serial_output #(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int BAUD_RATE       = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_in,
  input  logic        input_in_stb,
  output logic        input_in_ack,
  output logic        tx
);

  localparam int DIV   = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef SERIAL_OUTPUT_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

`ifdef SERIAL_OUTPUT_PARITY_EN
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic             ready_q, ready_d;
  logic             tx_q, tx_d;
  logic             baud_wrap;

  // Only the low byte is ever serialised; the upper bits are deliberately dropped.
  logic unused_hi;
  assign unused_hi = ^input_in[31:8];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    data_d       = data_q;
    ready_d      = 1'b1;
    input_in_ack = ready_q && (state_q == IDLE);
    baud_wrap    = (cnt_q == CNT_LAST);

    if (state_q != IDLE) begin
      cnt_d = baud_wrap ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (input_in_stb && input_in_ack) begin
          data_d  = input_in[7:0];
          state_d = START;
        end
      end
      START: if (baud_wrap) state_d = DATA;
      DATA: begin
        if (baud_wrap) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef SERIAL_OUTPUT_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef SERIAL_OUTPUT_PARITY_EN
      PARITY: if (baud_wrap) state_d = STOP;
`endif
      STOP: if (baud_wrap) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // tx is registered from the next-state decode so the line is glitch-free yet still
    // drops on the first cycle after the handshake edge.
    tx_d = 1'b1;
    case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = data_d[idx_d];
`ifdef SERIAL_OUTPUT_PARITY_EN
      PARITY: tx_d = even_parity(data_d);
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      tx_q    <= tx_d;
    end
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_serial_output.sv
// Bench for serial_output: table of words plus hand-written multi-cycle sequences, scoreboard of
// expected bytes consumed by a line monitor that checks every cycle of every bit.
module tb_serial_output;

  localparam int CLOCK_FREQUENCY = 50000000;
  localparam int BAUD_RATE       = 115200;
  localparam int DIV             = CLOCK_FREQUENCY / BAUD_RATE;
`ifdef SERIAL_OUTPUT_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FR = NB * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] input_in = '0;
  logic        input_in_stb = 1'b0;
  logic        input_in_ack;
  logic        tx;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [31:0] word;
    logic [7:0]  exp;
  } vec_t;
  vec_t vecs[5];

  serial_output #(
    .CLOCK_FREQUENCY(CLOCK_FREQUENCY),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .input_in(input_in),
    .input_in_stb(input_in_stb),
    .input_in_ack(input_in_ack),
    .tx(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got no event within cycle budget, expected event", name);
  endtask

  // Called on a negedge; returns on the negedge right after the handshake edge (e = cyc there).
  task automatic send(input logic [31:0] w, input bit hold, output int e);
    e = -1;
    input_in     = w;
    input_in_stb = 1'b1;
    for (int n = 0; n < 3 * FR; n++) begin
      if (input_in_ack === 1'b1) begin
        @(posedge clk);
        @(negedge clk);
        e = cyc;
        break;
      end
      @(negedge clk);
    end
    if (e < 0) fail_now("handshake");
    if (!hold) input_in_stb = 1'b0;
  endtask

  task automatic monitor(output int l, output logic [7:0] rcv);
    logic [7:0]    b;
    logic [NB-1:0] bits;
    int            bad;
    int            ack_hi;
    l      = -1;
    rcv    = '0;
    ack_hi = 0;
    for (int n = 0; n < 4 * FR; n++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        l = cyc;
        break;
      end
    end
    if (l < 0) begin
      fail_now("start bit");
      return;
    end
    if (exp_q.size() == 0) begin
      fail_now("scoreboard entry for frame");
      b = '0;
    end else begin
      b = exp_q.pop_front();
    end
`ifdef SERIAL_OUTPUT_PARITY_EN
    bits = {1'b1, ^b, b, 1'b0};
`else
    bits = {1'b1, b, 1'b0};
`endif
    for (int k = 0; k < NB; k++) begin
      bad = 0;
      for (int j = 0; j < DIV; j++) begin
        if (k != 0 || j != 0) @(negedge clk);
        if (tx !== bits[k]) bad++;
        if (input_in_ack !== 1'b0) ack_hi++;
        if (k >= 1 && k <= 8 && j == DIV / 2) rcv[k-1] = tx;
      end
      check($sformatf("frame bit %0d wrong cycles", k), bad, 0);
    end
    check("ack during frame", ack_hi, 0);
    @(negedge clk);
    check("ack after frame", input_in_ack, 1);
    check("frame length", cyc - l, FR);
  endtask

  initial begin
    #(2 * 200000 * 10);
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e1, e2, l1, l2, lows, ack_lo;
    logic [7:0] r1, r2;

    vecs[0] = '{32'h0000_0048, 8'h48};
    vecs[1] = '{32'hFFFF_FF07, 8'h07};
    vecs[2] = '{32'h0000_0007, 8'h07};
    vecs[3] = '{32'h1234_5603, 8'h03};
    vecs[4] = '{32'hDEAD_BE80, 8'h80};

    // Asynchronous reset with the clock still low.
    #2 rst = 1'b0;
    #1;
    check("reset tx", tx, 1);
    check("reset ack", input_in_ack, 0);
    repeat (3) @(negedge clk);
    check("ack held in reset", input_in_ack, 0);
    rst = 1'b1;
    #1 check("ack before first edge", input_in_ack, 0);
    @(negedge clk);
    check("ack after release", input_in_ack, 1);
    check("idle tx", tx, 1);

    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].exp);
      fork
        send(vecs[i].word, 1'b0, e1);
        monitor(l1, r1);
      join
      check($sformatf("latency vec %0d", i), l1 - e1, 0);
      check($sformatf("decoded byte vec %0d", i), r1, vecs[i].exp);
    end

    // Back-to-back "He" with stb held across both words.
    exp_q.push_back(8'h48);
    exp_q.push_back(8'h65);
    fork
      begin
        send(32'h0000_0048, 1'b1, e1);
        send(32'h0000_0065, 1'b0, e2);
      end
      begin
        monitor(l1, r1);
        monitor(l2, r2);
      end
    join
    check("b2b second handshake", e2 - e1, FR + 1);
    check("b2b second start", l2 - e2, 0);
    check("b2b decode", {r1, r2}, 16'h4865);

    // Strobe raised mid-frame must wait for IDLE.
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h3C);
    fork
      begin
        send(32'h0000_0055, 1'b0, e1);
        repeat (3 * DIV) @(negedge clk);
        send(32'h0000_003C, 1'b0, e2);
      end
      begin
        monitor(l1, r1);
        monitor(l2, r2);
      end
    join
    check("held-off handshake", e2 - e1, FR + 1);
    check("held-off decode", {r1, r2}, 16'h553C);

    // Strobe pulse that never meets a clock edge.
    input_in     = 32'h0000_0041;
    input_in_stb = 1'b1;
    #2 input_in_stb = 1'b0;
    lows   = 0;
    ack_lo = 0;
    repeat (2 * DIV) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (input_in_ack !== 1'b1) ack_lo++;
    end
    check("unsampled stb tx low cycles", lows, 0);
    check("unsampled stb ack low cycles", ack_lo, 0);

    // Reset 2000 cycles into a frame of all-zero data.
    send(32'h0000_0000, 1'b0, e1);
    repeat (1999) @(negedge clk);
    #1 check("tx low before abort", tx, 0);
    rst = 1'b0;
    #1;
    check("abort tx async", tx, 1);
    check("abort ack async", input_in_ack, 0);
    ack_lo = 0;
    repeat (3) begin
      @(negedge clk);
      if (input_in_ack !== 1'b0) ack_lo++;
    end
    check("ack high during reset cycles", ack_lo, 0);
    rst = 1'b1;
    @(negedge clk);
    check("ack after abort release", input_in_ack, 1);
    lows = 0;
    repeat (FR + DIV) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("residual bits after abort", lows, 0);

    exp_q.push_back(8'h5A);
    fork
      send(32'h0000_005A, 1'b0, e1);
      monitor(l1, r1);
    join
    check("recovery latency", l1 - e1, 0);
    check("recovery decode", r1, 8'h5A);
    check("scoreboard drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_output.md
SERIAL_OUTPUT -- requirements
Module: serial_output

Interface
REQ-001 Parameter CLOCK_FREQUENCY, default 50000000, meaning clk frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, meaning serial line rate in bit/s.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 input_in  input  32  data word from the stb/ack stream; only bits [7:0] are transmitted.
REQ-006 input_in_stb  input  1  producer asserts while input_in is valid.
REQ-007 input_in_ack  output  1  block asserts when able to accept a word.
REQ-008 tx  output  1  UART serial line, idle high.

Function
REQ-009 The block SHALL define DIV = CLOCK_FREQUENCY / BAUD_RATE, integer division with truncation; every serial bit SHALL last exactly DIV clk cycles.
REQ-010 The block SHALL implement the states IDLE, START, DATA, PARITY (only when configured in) and STOP.
REQ-011 In IDLE, input_in_ack SHALL be 1 and tx SHALL be 1.
REQ-012 A transfer SHALL occur on a rising edge where input_in_stb=1 and input_in_ack=1; the block SHALL latch input_in[7:0] and enter START, with input_in_ack=0 from the next cycle.
REQ-013 tx SHALL go low on the first cycle after the transfer edge, giving a latency of 1 cycle.
REQ-014 START SHALL drive tx=0 for DIV cycles, then go to DATA.
REQ-015 DATA SHALL drive the 8 latched bits LSB first, DIV cycles each, using a 3-bit index that counts 0..7; after bit 7 it SHALL go to PARITY if configured, else STOP.
REQ-016 STOP SHALL drive tx=1 for DIV cycles, then return to IDLE with input_in_ack=1 on the next cycle.
REQ-017 A back-to-back word SHALL therefore start its start bit exactly 1 cycle after the previous stop bit ends, with no extra idle bit.
REQ-018 The baud counter SHALL count 0..DIV-1, wrap to 0 at DIV-1 and advance the bit or state, and reset to 0 on every transfer.
REQ-019 input_in_ack SHALL be 0 in every state except IDLE; a strobe outside IDLE SHALL be held off without data loss, and the producer holds the word.
REQ-020 If input_in_stb drops in IDLE before being sampled, no transfer SHALL occur and tx SHALL stay 1.
REQ-021 input_in[31:8] SHALL be ignored and SHALL have no effect on tx.

Reset
REQ-022 When rst=0, the block SHALL immediately, without waiting for clk, force tx=1, the state to IDLE, the baud counter and bit index to 0, and the latched byte to 0.
REQ-023 While rst=0, input_in_ack SHALL be 0.
REQ-024 input_in_ack SHALL become 1 on the first rising edge after rst returns to 1.
REQ-025 A reset during a frame SHALL abort the frame; no partial bits SHALL resume afterwards.

Configuration
REQ-026 The macro SERIAL_OUTPUT_PARITY_EN SHALL control the PARITY state.
REQ-027 With SERIAL_OUTPUT_PARITY_EN defined, a PARITY state SHALL follow DATA and drive the even-parity bit (XOR of the 8 data bits) for DIV cycles, giving an 11-bit frame of 11*DIV cycles.
REQ-028 With SERIAL_OUTPUT_PARITY_EN undefined, the PARITY state and its logic SHALL be absent, giving a 10-bit frame of 10*DIV cycles.

Verification (CLOCK_FREQUENCY=50000000, BAUD_RATE=115200, DIV=434)
REQ-029 Send 0x00000048 with parity off -> tx low 1 cycle after the handshake; then 434-cycle bits 0,0,0,0,1,0,0,1,0,1 (start, LSB-first data, stop); input_in_ack returns to 1 exactly 4340 cycles after the handshake.
REQ-030 Send 0x00000048 then 0x00000065 back-to-back with stb held -> the second start bit begins 1 cycle after the first stop bit ends; 2 complete frames are received, decoding "He".
REQ-031 Send 0xFFFFFF07 -> the frame is identical to the one for 0x00000007 (data bits 1,1,1,0,0,0,0,0).
REQ-032 Pulse stb during the DATA state -> no ack and no change to the frame in progress; the word is accepted only once IDLE is reached.
REQ-033 Assert rst=0 for 3 cycles 2000 cycles into a frame -> tx=1 asynchronously with no clk edge; input_in_ack=0 during reset and 1 on the first edge after release; no residual bits.
REQ-034 With SERIAL_OUTPUT_PARITY_EN defined, send 0x00000007 -> parity bit 1 and frame length 4774 cycles; send 0x00000003 -> parity bit 0.
